// File: rtl/oai211_chk_pkg.sv
// rtl/oai211_chk_pkg.sv - shared types and constants for the OAI211 response checker
package oai211_chk_pkg;

  localparam int IDX_W     = 4;
  localparam int NUM_VEC   = 1 << IDX_W;
  localparam int LOG_DEPTH = 4;
  localparam int ENTRY_W   = IDX_W + 1;

  // Expected ZN per vector index {a,b,c1,c2}; only 13, 14 and 15 drive ZN low.
  localparam logic [NUM_VEC-1:0] EXP_ZN_TABLE = 16'h1FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/oai211_chk_errlog.sv
// rtl/oai211_chk_errlog.sv - records {zn, idx} of the first four mismatches
module oai211_chk_errlog
  import oai211_chk_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic                           zn,
  input  logic [IDX_W-1:0]               idx,
  output logic [LOG_DEPTH*ENTRY_W-1:0]   err_log,
  output logic [2:0]                     err_log_cnt
);

  // Append one entry per mismatch until the log is full; later mismatches are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      err_log     <= '0;
      err_log_cnt <= '0;
    end else if (wr_en && (err_log_cnt != 3'(LOG_DEPTH))) begin
      for (int k = 0; k < LOG_DEPTH; k++) begin
        if (err_log_cnt == 3'(k)) begin
          err_log[k*ENTRY_W +: ENTRY_W] <= {zn, idx};
        end
      end
      err_log_cnt <= err_log_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/oai211_resp_checker.sv
// rtl/oai211_resp_checker.sv - exhaustive OAI211 response checker; optional log via OAI211_CHK_ERRLOG_EN
module oai211_resp_checker
  import oai211_chk_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         a,
  input  logic                         b,
  input  logic                         c1,
  input  logic                         c2,
  input  logic                         zn,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ERR_W-1:0]             err_cnt,
  output logic [NUM_VEC-1:0]           cov_map,
  output logic [ENTRY_W-1:0]           first_fail,
  output logic [LOG_DEPTH*ENTRY_W-1:0] err_log,
  output logic [2:0]                   err_log_cnt
);

  // Counter starts at SETTLE-1 so the SETTLE state lasts exactly SETTLE cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE > 0 ? SETTLE - 1 : 0);

  state_t             state, state_nxt;
  logic [3:0]         settle_cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_VEC-1:0] cov_set;
  logic               clr, accept, check, mismatch;

  assign cov_set  = cov_map | (NUM_VEC'(1) << idx_q);
  assign mismatch = check & (zn != EXP_ZN_TABLE[idx_q]);
  assign pass     = done & (err_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state controls; start only takes effect from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    clr       = 1'b0;
    accept    = 1'b0;
    check     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        busy      = 1'b1;
        check     = 1'b1;
        state_nxt = (cov_set == '1) ? ST_DONE : ST_ARMED;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          clr       = 1'b1;
          state_nxt = ST_ARMED;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Vector latch, settle countdown and campaign status (coverage, errors, first failure).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      cov_map    <= '0;
      first_fail <= '0;
    end else begin
      if (clr) begin
        err_cnt    <= '0;
        cov_map    <= '0;
        first_fail <= '0;
      end
      if (accept) begin
        idx_q      <= {a, b, c1, c2};
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && (settle_cnt != 4'd0)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (check) begin
        cov_map <= cov_set;
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          if (!first_fail[ENTRY_W-1]) first_fail <= {1'b1, idx_q};
        end
      end
    end
  end

`ifdef OAI211_CHK_ERRLOG_EN
  oai211_chk_errlog u_errlog (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr_en       (mismatch),
    .zn          (zn),
    .idx         (idx_q),
    .err_log     (err_log),
    .err_log_cnt (err_log_cnt)
  );
`else
  assign err_log     = '0;
  assign err_log_cnt = '0;
`endif

endmodule

// File: tb/tb_oai211_resp_checker.sv
// tb/tb_oai211_resp_checker.sv - directed self-checking bench for oai211_resp_checker
module tb_oai211_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        a = 1'b0, b = 1'b0, c1 = 1'b0, c2 = 1'b0, zn = 1'b1;

  logic        in_ready, busy, done, pass;
  logic [7:0]  err_cnt;
  logic [15:0] cov_map;
  logic [4:0]  first_fail;
  logic [19:0] err_log;
  logic [2:0]  err_log_cnt;

  logic        in_ready_0, busy_0, done_0, pass_0;
  logic [7:0]  err_cnt_0;
  logic [15:0] cov_map_0;
  logic [4:0]  first_fail_0;
  logic [19:0] err_log_0;
  logic [2:0]  err_log_cnt_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oai211_resp_checker #(.SETTLE(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c1(c1), .c2(c2), .zn(zn),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov_map(cov_map),
    .first_fail(first_fail), .err_log(err_log), .err_log_cnt(err_log_cnt)
  );

  oai211_resp_checker #(.SETTLE(0), .ERR_W(8)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_0),
    .a(a), .b(b), .c1(c1), .c2(c2), .zn(zn),
    .busy(busy_0), .done(done_0), .pass(pass_0), .err_cnt(err_cnt_0), .cov_map(cov_map_0),
    .first_fail(first_fail_0), .err_log(err_log_0), .err_log_cnt(err_log_cnt_0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_zn(input logic [3:0] v);
    return ~((v[1] | v[0]) & v[3] & v[2]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [3:0] v, input logic zv);
    int n;
    @(negedge clk);
    {a, b, c1, c2} = v;
    zn = zv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(in_ready || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(in_ready || done)) chk("check_timeout", in_ready, 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_cov_map", cov_map, 0);
    chk("rst_first_fail", first_fail, 0);
    chk("rst_err_log", err_log, 0);
    chk("rst_err_log_cnt", err_log_cnt, 0);

    // Correct-cell sweep
    do_start();
    chk("armed_ready", in_ready, 1);
    chk("armed_busy", busy, 1);
    for (int i = 0; i < 16; i++) send_vec(4'(i), model_zn(4'(i)));
    chk("sweep_done", done, 1);
    chk("sweep_pass", pass, 1);
    chk("sweep_err_cnt", err_cnt, 0);
    chk("sweep_cov_map", cov_map, 32'hFFFF);
    chk("sweep_first_fail", first_fail, 0);
    chk("sweep_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    chk("done_hold_cov", cov_map, 32'hFFFF);

    // Stuck-at-1 cell
    do_start();
    chk("restart_cov_clr", cov_map, 0);
    chk("restart_busy", busy, 1);
    for (int i = 0; i < 16; i++) send_vec(4'(i), 1'b1);
    chk("sa1_done", done, 1);
    chk("sa1_err_cnt", err_cnt, 3);
    chk("sa1_first_fail", first_fail, 5'h1D);
    chk("sa1_pass", pass, 0);
`ifdef OAI211_CHK_ERRLOG_EN
    chk("sa1_log_cnt", err_log_cnt, 3);
    chk("sa1_log", err_log, 20'h07FDD);
`else
    chk("sa1_log_cnt", err_log_cnt, 0);
    chk("sa1_log", err_log, 0);
`endif

    // Repeated vector, third copy with a wrong response
    do_start();
    send_vec(4'd5, model_zn(4'd5));
    send_vec(4'd5, model_zn(4'd5));
    send_vec(4'd5, ~model_zn(4'd5));
    chk("rep_cov", cov_map, 32'h0020);
    chk("rep_err_cnt", err_cnt, 1);
    chk("rep_not_done", done, 0);
    for (int i = 0; i < 15; i++) if (i != 5) send_vec(4'(i), model_zn(4'(i)));
    chk("rep_cov15", cov_map, 32'h7FFF);
    chk("rep_done15", done, 0);
    send_vec(4'd15, model_zn(4'd15));
    chk("rep_done16", done, 1);
    chk("rep_first_fail", first_fail, 5'h15);

    // Start pulsed while ARMED is ignored
    do_start();
    send_vec(4'd0, 1'b0);
    send_vec(4'd1, model_zn(4'd1));
    send_vec(4'd2, model_zn(4'd2));
    do_start();
    chk("ign_err_cnt", err_cnt, 1);
    chk("ign_cov", cov_map, 32'h0007);
    chk("ign_ready", in_ready, 1);
    for (int i = 3; i < 16; i++) send_vec(4'(i), model_zn(4'(i)));
    chk("ign_done", done, 1);
    chk("ign_final_err", err_cnt, 1);
    chk("ign_first_fail", first_fail, 5'h10);
    chk("ign_pass", pass, 0);

    // Reset during SETTLE after seven vectors
    do_start();
    for (int i = 0; i < 7; i++) send_vec(4'(i), model_zn(4'(i)));
    @(negedge clk);
    {a, b, c1, c2} = 4'd7;
    zn = model_zn(4'd7);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_settle_busy", busy, 1);
    chk("mid_settle_ready", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cov", cov_map, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_ff", first_fail, 0);
    do_start();
    for (int i = 0; i < 15; i++) send_vec(4'(i), model_zn(4'(i)));
    chk("post_rst_done15", done, 0);
    send_vec(4'd15, model_zn(4'd15));
    chk("post_rst_done16", done, 1);
    chk("post_rst_pass", pass, 1);

    // SETTLE timing: response becomes correct two cycles after accept
    do_reset();
    do_start();
    {a, b, c1, c2} = 4'd15;
    zn = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    zn = 1'b0;
    repeat (3) @(negedge clk);
    chk("settle2_err", err_cnt, 0);
    chk("settle2_cov", cov_map, 32'h8000);
    chk("settle0_err", err_cnt_0, 1);
    chk("settle0_ff", first_fail_0, 5'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
